// File: rtl/fwd_pkg.sv
// Shared types for the EXE-stage forwarding/hazard controller: select codes, in-flight
// destination tag slot, controller state, and the slot/source match helper.
package fwd_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        SEL_NONE    = 2'b00,
        SEL_EXE_MEM = 2'b01,
        SEL_WB      = 2'b10,
        SEL_DCACHE  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } fwd_slot_t;

    typedef enum logic [1:0] {
        RUN,
        BUBBLE,
        MISS
    } fwd_state_e;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic slot_match(input fwd_slot_t slot, input logic [REG_AW-1:0] rs,
                                        input logic rs_used);
        return slot.valid & slot.reg_write & (slot.rd != '0) & (slot.rd == rs) & rs_used;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand forwarding select: nearest producer wins (EXE slot before MEM slot).
module fwd_match
    import fwd_pkg::*;
(
    input  fwd_slot_t         exe_slot_i,
    input  fwd_slot_t         mem_slot_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic              rs_used_i,
    output fwd_sel_e          sel_o
);

    always_comb begin
        sel_o = SEL_NONE;
        if (slot_match(exe_slot_i, rs_i, rs_used_i)) begin
            sel_o = exe_slot_i.mem_read ? SEL_DCACHE : SEL_EXE_MEM;
        end else if (slot_match(mem_slot_i, rs_i, rs_used_i)) begin
            sel_o = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ID-stage forwarding/hazard controller: registers EXE operand selects and drives IF/ID stall and
// ID/EXE bubble. Define FWD_LOAD_BUBBLE_EN to turn load-use dependences into a one-cycle bubble.
module fwd_hazard_ctrl
    import fwd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_src2_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              branch_flush,
    input  logic              dcache_stall,
    output logic [1:0]        rs_sel,
    output logic [1:0]        rt_sel,
    output logic              stall_if_id,
    output logic              bubble_id_exe
);

`ifdef FWD_LOAD_BUBBLE_EN
    localparam bit LoadBubbleEn = 1'b1;
`else
    localparam bit LoadBubbleEn = 1'b0;
`endif

    fwd_slot_t  exe_q, exe_d, mem_q, mem_d;
    fwd_state_e state_q, state_d;
    logic [1:0] rs_sel_q, rs_sel_d, rt_sel_q, rt_sel_d;
    fwd_sel_e   rs1_fwd, rs2_fwd;
    fwd_slot_t  id_tag;
    logic       load_use;

    fwd_match u_match_rs1 (
        .exe_slot_i (exe_q),
        .mem_slot_i (mem_q),
        .rs_i       (id_rs1),
        .rs_used_i  (id_rs1_used),
        .sel_o      (rs1_fwd)
    );

    fwd_match u_match_rs2 (
        .exe_slot_i (exe_q),
        .mem_slot_i (mem_q),
        .rs_i       (id_rs2),
        .rs_used_i  (id_rs2_used),
        .sel_o      (rs2_fwd)
    );

    assign id_tag = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    // A flushed consumer never needs its operand, so it cannot cause a load-use bubble.
    assign load_use = LoadBubbleEn & id_valid & ~branch_flush & (state_q != BUBBLE) &
                      ((rs1_fwd == SEL_DCACHE) | (rs2_fwd == SEL_DCACHE));

    always_comb begin
        state_d       = state_q;
        exe_d         = exe_q;
        mem_d         = mem_q;
        rs_sel_d      = rs_sel_q;
        rt_sel_d      = rt_sel_q;
        stall_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        if (dcache_stall) begin
            stall_if_id = 1'b1;
            state_d     = MISS;
        end else begin
            stall_if_id   = load_use;
            bubble_id_exe = load_use;
            state_d       = load_use ? BUBBLE : RUN;
            mem_d         = exe_q;
            if (id_valid & ~branch_flush & ~load_use) begin
                exe_d    = id_tag;
                rs_sel_d = rs1_fwd;
                rt_sel_d = id_src2_imm ? SEL_NONE : rs2_fwd;
            end else begin
                exe_d    = '0;
                rs_sel_d = SEL_NONE;
                rt_sel_d = SEL_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            exe_q    <= '0;
            mem_q    <= '0;
            rs_sel_q <= SEL_NONE;
            rt_sel_q <= SEL_NONE;
        end else begin
            state_q  <= state_d;
            exe_q    <= exe_d;
            mem_q    <= mem_d;
            rs_sel_q <= rs_sel_d;
            rt_sel_q <= rt_sel_d;
        end
    end

    assign rs_sel = rs_sel_q;
    assign rt_sel = rt_sel_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; expectations follow FWD_LOAD_BUBBLE_EN when it is defined.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs1_used, id_rs2_used, id_src2_imm, id_reg_write, id_mem_read;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_flush, dcache_stall;
    logic [1:0] rs_sel, rt_sel;
    logic       stall_if_id, bubble_id_exe;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_src2_imm   (id_src2_imm),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .branch_flush  (branch_flush),
        .dcache_stall  (dcache_stall),
        .rs_sel        (rs_sel),
        .rt_sel        (rt_sel),
        .stall_if_id   (stall_if_id),
        .bubble_id_exe (bubble_id_exe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic imm, input logic [4:0] rd, input logic rw,
                       input logic mr);
        id_valid     = 1'b1;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_src2_imm  = imm;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic idle(input int n);
        id_valid     = 1'b0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        id_src2_imm  = 1'b0;
        branch_flush = 1'b0;
        dcache_stall = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(0);
        id_rs1 = '0;
        id_rs2 = '0;
        id_rd  = '0;
        #2;
        n_cmp++; if (rs_sel !== 2'b00) begin n_bad++; $display("FAIL reset_rs_sel got %b exp 00", rs_sel); end
        n_cmp++; if (rt_sel !== 2'b00) begin n_bad++; $display("FAIL reset_rt_sel got %b exp 00", rt_sel); end
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall_if_id); end
        n_cmp++; if (bubble_id_exe !== 1'b0) begin n_bad++; $display("FAIL reset_bubble got %b exp 0", bubble_id_exe); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exe_fwd();
        idle(2);
        put(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        put(5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        n_cmp++; if (rs_sel !== 2'b01) begin n_bad++; $display("FAIL exe_rs_sel got %b exp 01", rs_sel); end
        n_cmp++; if (rt_sel !== 2'b00) begin n_bad++; $display("FAIL exe_rt_sel got %b exp 00", rt_sel); end
    endtask

    task automatic test_wb_fwd_and_x0();
        idle(2);
        put(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        idle(1);
        put(5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL wb_stall got %b exp 0", stall_if_id); end
        tick();
        n_cmp++; if (rt_sel !== 2'b10) begin n_bad++; $display("FAIL wb_rt_sel got %b exp 10", rt_sel); end
        n_cmp++; if (rs_sel !== 2'b00) begin n_bad++; $display("FAIL wb_rs_sel got %b exp 00", rs_sel); end
        put(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        put(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        tick();
        n_cmp++; if (rs_sel !== 2'b00) begin n_bad++; $display("FAIL x0_rs_sel got %b exp 00", rs_sel); end
        n_cmp++; if (rt_sel !== 2'b00) begin n_bad++; $display("FAIL x0_rt_sel got %b exp 00", rt_sel); end
        idle(2);
        put(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        put(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        n_cmp++; if (rt_sel !== 2'b00) begin n_bad++; $display("FAIL imm_rt_sel got %b exp 00", rt_sel); end
    endtask

    task automatic test_load_use();
        idle(2);
        put(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        put(5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
`ifdef FWD_LOAD_BUBBLE_EN
        n_cmp++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b exp 1", stall_if_id); end
        n_cmp++; if (bubble_id_exe !== 1'b1) begin n_bad++; $display("FAIL lu_bubble got %b exp 1", bubble_id_exe); end
        tick();
        n_cmp++; if (rs_sel !== 2'b00) begin n_bad++; $display("FAIL lu_bub_rs_sel got %b exp 00", rs_sel); end
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL lu_stall2 got %b exp 0", stall_if_id); end
        n_cmp++; if (bubble_id_exe !== 1'b0) begin n_bad++; $display("FAIL lu_bubble2 got %b exp 0", bubble_id_exe); end
        tick();
        n_cmp++; if (rs_sel !== 2'b10) begin n_bad++; $display("FAIL lu_rs_sel got %b exp 10", rs_sel); end
`else
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL lu_stall got %b exp 0", stall_if_id); end
        n_cmp++; if (bubble_id_exe !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %b exp 0", bubble_id_exe); end
        tick();
        n_cmp++; if (rs_sel !== 2'b11) begin n_bad++; $display("FAIL lu_rs_sel got %b exp 11", rs_sel); end
`endif
        n_cmp++; if (rt_sel !== 2'b00) begin n_bad++; $display("FAIL lu_rt_sel got %b exp 00", rt_sel); end
    endtask

    task automatic test_dcache_stall();
        idle(2);
        put(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        put(5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (rs_sel !== 2'b01) begin n_bad++; $display("FAIL miss_pre_rs_sel got %b exp 01", rs_sel); end
        put(5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        dcache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL miss_stall[%0d] got %b exp 1", i, stall_if_id); end
            n_cmp++; if (bubble_id_exe !== 1'b0) begin n_bad++; $display("FAIL miss_bubble[%0d] got %b exp 0", i, bubble_id_exe); end
            tick();
            n_cmp++; if (rs_sel !== 2'b01) begin n_bad++; $display("FAIL miss_hold_rs_sel[%0d] got %b exp 01", i, rs_sel); end
        end
        dcache_stall = 1'b0;
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL miss_exit_stall got %b exp 0", stall_if_id); end
        tick();
        n_cmp++; if (rs_sel !== 2'b10) begin n_bad++; $display("FAIL miss_post_rs_sel got %b exp 10", rs_sel); end
    endtask

    task automatic test_flush_load_use();
        idle(2);
        put(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        put(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        branch_flush = 1'b1;
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b exp 0", stall_if_id); end
        n_cmp++; if (bubble_id_exe !== 1'b0) begin n_bad++; $display("FAIL flush_bubble got %b exp 0", bubble_id_exe); end
        tick();
        n_cmp++; if (rs_sel !== 2'b00) begin n_bad++; $display("FAIL flush_rs_sel got %b exp 00", rs_sel); end
        n_cmp++; if (rt_sel !== 2'b00) begin n_bad++; $display("FAIL flush_rt_sel got %b exp 00", rt_sel); end
        branch_flush = 1'b0;
        put(5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL flush_next_stall got %b exp 0", stall_if_id); end
        tick();
        n_cmp++; if (rs_sel !== 2'b10) begin n_bad++; $display("FAIL flush_next_rs_sel got %b exp 10", rs_sel); end
    endtask

    task automatic test_reset_in_miss();
        idle(2);
        put(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        put(5'd9, 5'd1, 1'b1, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
        tick();
        n_cmp++; if (rs_sel !== 2'b01) begin n_bad++; $display("FAIL rmiss_pre_rs_sel got %b exp 01", rs_sel); end
        dcache_stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rs_sel !== 2'b00) begin n_bad++; $display("FAIL rmiss_rs_sel got %b exp 00", rs_sel); end
        n_cmp++; if (rt_sel !== 2'b00) begin n_bad++; $display("FAIL rmiss_rt_sel got %b exp 00", rt_sel); end
        dcache_stall = 1'b0;
        #1;
        n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL rmiss_stall got %b exp 0", stall_if_id); end
        n_cmp++; if (bubble_id_exe !== 1'b0) begin n_bad++; $display("FAIL rmiss_bubble got %b exp 0", bubble_id_exe); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (rs_sel !== 2'b00) begin n_bad++; $display("FAIL rmiss_post_rs_sel got %b exp 00", rs_sel); end
    endtask

    initial begin
        test_reset();
        test_exe_fwd();
        test_wb_fwd_and_x0();
        test_load_use();
        test_dcache_stall();
        test_flush_load_use();
        test_reset_in_miss();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
